rc4_swap_engine: RTL and testbench



---
 rtl/rc4_swap_engine.sv | 135 +++++++++++++
 tb/tb_rc4_swap_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_swap_engine.sv
// RC4 index-update and S-box swap engine working directly against an external
// single-port S memory. One start performs one i iteration in KSA or PRGA mode.
module rc4_swap_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [ADDR_W-1:0] j_in,
  input  logic [DATA_W-1:0] key_byte,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] j_out,
  output logic [DATA_W-1:0] si_out,
  output logic [DATA_W-1:0] sj_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 3;
  localparam int SUM_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

  typedef enum logic [6:0] {
    IDLE   = 7'b0000001,
    RD_I   = 7'b0000010,
    CALC_J = 7'b0000100,
    RD_J   = 7'b0001000,
    WR_I   = 7'b0010000,
    WR_J   = 7'b0100000,
    DONE   = 7'b1000000
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lat_cnt;
  logic               lat_last;
  logic [ADDR_W-1:0]  i_p0, j_p0, j_calc;
  logic [DATA_W-1:0]  key_p0, si_p1, sj_p1;
  logic               mode_p0;

  // An S value used as an index: truncate or zero-extend to the index width.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [SUM_W-1:0] t;
    t = SUM_W'(v);
    return t[ADDR_W-1:0];
  endfunction

  assign lat_last = (lat_cnt == CNT_W'(READ_LAT - 1));
  assign j_calc   = j_p0 + to_addr(si_p1) + (mode_p0 ? '0 : to_addr(key_p0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      j_out   <= '0;
      si_out  <= '0;
      sj_out  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == RD_I || state == RD_J) && !lat_last)
        lat_cnt <= lat_cnt + 1'b1;
      else
        lat_cnt <= '0;
      if (state == WR_J) begin
        j_out  <= j_p0;
        si_out <= si_p1;
        sj_out <= sj_p1;
      end
    end
  end

  // Stage p0: request latch and j update; stage p1: captured S[i] and S[j]
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      i_p0    <= i_idx;
      j_p0    <= j_in;
      key_p0  <= key_byte;
      mode_p0 <= mode;
    end else if (state == CALC_J) begin
      j_p0 <= j_calc;
    end
    if (state == RD_I && lat_last) si_p1 <= mem_rdata;
    if (state == RD_J && lat_last) sj_p1 <= mem_rdata;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        state_nxt = start ? RD_I : IDLE;
      end
      RD_I: begin
        mem_addr  = i_p0;
        state_nxt = lat_last ? CALC_J : RD_I;
      end
      CALC_J: state_nxt = RD_J;
      RD_J: begin
        mem_addr  = j_p0;
        state_nxt = lat_last ? WR_I : RD_J;
      end
      WR_I: begin
        mem_addr  = i_p0;
        mem_wdata = sj_p1;
        mem_wren  = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        mem_addr  = j_p0;
        mem_wdata = si_p1;
        mem_wren  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_swap_engine.sv
// Directed bench for rc4_swap_engine: a READ_LAT=2 instance on a registered-address
// memory and a READ_LAT=1 instance on an asynchronous-read memory.
module tb_rc4_swap_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, start_a, mode_a, busy_a, done_a, wren_a;
  logic [7:0] i_a, j_a, key_a, jo_a, si_a, sj_a, addr_a, wdata_a, rdata_a, addr_q_a;
  logic       reset_b, start_b, mode_b, busy_b, done_b, wren_b;
  logic [7:0] i_b, j_b, key_b, jo_b, si_b, sj_b, addr_b, wdata_b, rdata_b;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       load_id;

  int n_cmp = 0;
  int n_err = 0;

  rc4_swap_engine #(.DATA_W(8), .ADDR_W(8), .READ_LAT(2)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .mode(mode_a), .i_idx(i_a),
    .j_in(j_a), .key_byte(key_a), .busy(busy_a), .done(done_a), .j_out(jo_a),
    .si_out(si_a), .sj_out(sj_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .mem_wren(wren_a), .mem_rdata(rdata_a));

  rc4_swap_engine #(.DATA_W(8), .ADDR_W(8), .READ_LAT(1)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .mode(mode_b), .i_idx(i_b),
    .j_in(j_b), .key_byte(key_b), .busy(busy_b), .done(done_b), .j_out(jo_b),
    .si_out(si_b), .sj_out(sj_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_wren(wren_b), .mem_rdata(rdata_b));

  // M10K-like memory (registered address) for A, asynchronous read for B
  always @(posedge clk) begin
    if (load_id) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] <= 8'(k);
        mem_b[k] <= 8'(k);
      end
    end else begin
      if (wren_a) mem_a[addr_a] <= wdata_a;
      if (wren_b) mem_b[addr_b] <= wdata_b;
    end
    addr_q_a <= addr_a;
  end
  assign rdata_a = mem_a[addr_q_a];
  assign rdata_b = mem_b[addr_b];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reload();
    @(negedge clk) load_id = 1'b1;
    @(negedge clk) load_id = 1'b0;
  endtask

  // One operation on instance A (sel=0) or B (sel=1); returns edges from the
  // start-sampling edge to the DONE cycle, and write cycles seen before done.
  task automatic do_op(input bit sel, input logic m, input logic [7:0] i, input logic [7:0] j,
                       input logic [7:0] k, output int lat, output int wr);
    int cyc;
    @(negedge clk);
    if (sel) begin mode_b = m; i_b = i; j_b = j; key_b = k; start_b = 1'b1; end
    else     begin mode_a = m; i_a = i; j_a = j; key_a = k; start_a = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 0;
    wr  = 0;
    while (cyc < 40) begin
      if (sel ? done_b : done_a) break;
      if (sel ? wren_b : wren_a) wr++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) chk("op_timeout", 32'(cyc), 32'd0);
    lat = cyc;
  endtask

  initial begin
    int lat, wr, diffs, cyc, nd, extra;
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0; load_id = 1'b0;
    mode_a = 1'b0; i_a = '0; j_a = '0; key_a = '0;
    mode_b = 1'b0; i_b = '0; j_b = '0; key_b = '0;
    reload();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_wren", 32'(wren_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_jout", 32'(jo_a), 32'd0);
    chk("rst_si_sj", {16'd0, si_a, sj_a}, 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // KSA: j = 10 + 3 + 0x20 = 0x2D
    do_op(1'b0, 1'b0, 8'd3, 8'd10, 8'h20, lat, wr);
    chk("t1_jout", 32'(jo_a), 32'h2D);
    chk("t1_si", 32'(si_a), 32'h03);
    chk("t1_sj", 32'(sj_a), 32'h2D);
    chk("t1_lat", 32'(lat), 32'd7);
    chk("t1_writes", 32'(wr), 32'd2);
    chk("t1_S3", 32'(mem_a[3]), 32'h2D);
    chk("t1_S2D", 32'(mem_a[8'h2D]), 32'h03);

    // PRGA with wrap, key ignored: 0x20 + 0xF0 = 0x110 -> 0x10
    reload();
    do_op(1'b0, 1'b1, 8'hF0, 8'h20, 8'hFF, lat, wr);
    chk("t2_jout", 32'(jo_a), 32'h10);
    chk("t2_si", 32'(si_a), 32'hF0);
    chk("t2_sj", 32'(sj_a), 32'h10);
    chk("t2_SF0", 32'(mem_a[8'hF0]), 32'h10);
    chk("t2_S10", 32'(mem_a[8'h10]), 32'hF0);

    // i == j
    reload();
    do_op(1'b0, 1'b1, 8'd5, 8'd0, 8'h00, lat, wr);
    chk("t3_jout", 32'(jo_a), 32'h05);
    chk("t3_si_sj", {16'd0, si_a, sj_a}, 32'h0505);
    diffs = 0;
    for (int k = 0; k < 256; k++) if (mem_a[k] != 8'(k)) diffs++;
    chk("t3_unchanged", 32'(diffs), 32'd0);

    // Reset during the WR_I cycle
    reload();
    @(negedge clk);
    mode_a = 1'b0; i_a = 8'd3; j_a = 8'd10; key_a = 8'h20; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
    while (!wren_a && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_reach_wr_i", 32'(cyc), 32'd5);
    reset_a = 1'b1;
    @(negedge clk);
    chk("t4_busy", 32'(busy_a), 32'd0);
    chk("t4_wren", 32'(wren_a), 32'd0);
    chk("t4_jout_clr", 32'(jo_a), 32'd0);
    reset_a = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a || wren_a) extra++;
    end
    chk("t4_no_done_wr", 32'(extra), 32'd0);
    chk("t4_S3", 32'(mem_a[3]), 32'h2D);
    chk("t4_S2D", 32'(mem_a[8'h2D]), 32'h2D);

    // start held high across three back-to-back operations
    reload();
    @(negedge clk);
    mode_a = 1'b0; i_a = 8'd1; j_a = 8'd0; key_a = 8'd1; start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0; nd = 0; wr = 0;
    while (cyc < 100) begin
      if (wren_a) wr++;
      if (done_a) begin
        nd++;
        if (nd == 3) begin
          start_a = 1'b0;
          break;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("t5_third_done", 32'(cyc), 32'd25);
    chk("t5_writes", 32'(wr), 32'd6);
    chk("t5_jout", 32'(jo_a), 32'h04);
    chk("t5_si_sj", {16'd0, si_a, sj_a}, 32'h0304);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a || wren_a) extra++;
    end
    chk("t5_no_extra", 32'(extra), 32'd0);
    chk("t5_S1_4", {mem_a[1], mem_a[2], mem_a[3], mem_a[4]}, 32'h04010203);

    // READ_LAT=1 instance, KSA stimulus
    do_op(1'b1, 1'b0, 8'd3, 8'd10, 8'h20, lat, wr);
    chk("t6_jout", 32'(jo_b), 32'h2D);
    chk("t6_si_sj", {16'd0, si_b, sj_b}, 32'h032D);
    chk("t6_lat", 32'(lat), 32'd5);
    chk("t6_writes", 32'(wr), 32'd2);
    chk("t6_mem", {16'd0, mem_b[3], mem_b[8'h2D]}, 32'h2D03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
